pulse_blinker: RTL and testbench

Output-side companion to the button debouncer. It takes single-cycle event pulses from `debounce_pulse` or any FSM strobe and turns each one into a human-visible LED blink of fixed on-time followed by a fixed dark gap. Events that arrive while a blink is in progress are counted and replayed in order, so no press is visually lost. It sits between pulse-producing logic and an LED pin on the icezum test harness.

---
 rtl/pulse_blinker.sv | 113 +++++++++++
 tb/tb_pulse_blinker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_blinker.sv
// Stretches single-cycle event strobes into fixed-length LED blinks separated by a dark gap.
// Events that arrive mid-blink are queued in a saturating counter and replayed in arrival order.
module pulse_blinker #(
    parameter int N      = 22,
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pulse_in,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [N-1:0]      TIMER_MAX = {N{1'b1}};
    localparam logic [N-1:0]      TIMER_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [N-1:0]      timer_reg, timer_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              led_reg;
    logic              ovf_reg, ovf_next;
    logic              consume, dec, inc;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        consume    = 1'b0;
        dec        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (pulse_in) begin
                    state_next = S_ON;
                    consume    = 1'b1;
                end else if (pend_reg != '0) begin
                    state_next = S_ON;
                    dec        = 1'b1;
                end
            end
            S_ON: begin
                timer_next = timer_reg + TIMER_ONE;
                if (timer_reg == TIMER_MAX) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                timer_next = timer_reg + TIMER_ONE;
                if (timer_reg == TIMER_MAX) begin
                    // Queued events go first; a fresh pulse then joins the back of the queue.
                    if (pend_reg != '0) begin
                        state_next = S_ON;
                        dec        = 1'b1;
                    end else if (pulse_in) begin
                        state_next = S_ON;
                        consume    = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase

        inc       = pulse_in && !consume;
        pend_next = pend_reg;
        ovf_next  = ovf_reg;
        if (inc && !dec) begin
            if (pend_reg == PEND_MAX) begin
                ovf_next = 1'b1;
            end else begin
                pend_next = pend_reg + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pend_next = pend_reg - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
            pend_reg  <= '0;
            led_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            pend_reg  <= pend_next;
            led_reg   <= (state_next == S_ON);
            ovf_reg   <= ovf_next;
        end
    end

    assign led     = led_reg;
    assign busy    = (state_reg != S_IDLE) || (pend_reg != '0);
    assign pending = pend_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with N=2 (4-cycle on, 4-cycle gap) and PEND_W=2 (queue max 3).
// "Edge e" is the e-th rising edge of a scenario; outputs are sampled 1 time unit after it.
module tb_pulse_blinker;

    logic       clk;
    logic       rstn;
    logic       pulse_in;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       ovf;

    int total;
    int bad;

    pulse_blinker #(.N(2), .PEND_W(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .pulse_in(pulse_in),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(1'b0);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", led); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if (pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        $display("test_reset: led=%b busy=%b pending=%0d ovf=%b", led, busy, pending, ovf);
    endtask

    task automatic test_single();
        logic exp_led, exp_busy;
        do_reset();
        for (int e = 0; e <= 9; e++) begin
            step(e == 0);
            exp_led  = (e <= 3);
            exp_busy = (e <= 7);
            total++;
            if (led !== exp_led) begin bad++; $display("FAIL single_led e=%0d got=%b exp=%b", e, led, exp_led); end
            total++;
            if (busy !== exp_busy) begin bad++; $display("FAIL single_busy e=%0d got=%b exp=%b", e, busy, exp_busy); end
            total++;
            if (pending !== 2'd0) begin bad++; $display("FAIL single_pending e=%0d got=%0d exp=0", e, pending); end
        end
        $display("test_single: one blink checked over 10 edges");
    endtask

    task automatic test_burst();
        logic       exp_led, exp_busy;
        logic [1:0] exp_pend;
        do_reset();
        for (int e = 0; e <= 26; e++) begin
            step(e <= 2);
            exp_led  = ((e % 8) < 4) && (e < 24);
            exp_busy = (e < 24);
            if (e == 0)      exp_pend = 2'd0;
            else if (e == 1) exp_pend = 2'd1;
            else if (e < 8)  exp_pend = 2'd2;
            else if (e < 16) exp_pend = 2'd1;
            else             exp_pend = 2'd0;
            total++;
            if (led !== exp_led) begin bad++; $display("FAIL burst_led e=%0d got=%b exp=%b", e, led, exp_led); end
            total++;
            if (busy !== exp_busy) begin bad++; $display("FAIL burst_busy e=%0d got=%b exp=%b", e, busy, exp_busy); end
            total++;
            if (pending !== exp_pend) begin bad++; $display("FAIL burst_pending e=%0d got=%0d exp=%0d", e, pending, exp_pend); end
        end
        $display("test_burst: three queued blinks checked over 27 edges");
    endtask

    task automatic test_overflow();
        int   blinks;
        logic prev_led;
        logic exp_ovf;
        do_reset();
        blinks   = 0;
        prev_led = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            step(e <= 4);
            if (led && !prev_led) blinks++;
            prev_led = led;
            exp_ovf  = (e >= 4);
            total++;
            if (ovf !== exp_ovf) begin bad++; $display("FAIL ovf_flag e=%0d got=%b exp=%b", e, ovf, exp_ovf); end
            if (e == 3 || e == 4) begin
                total++;
                if (pending !== 2'd3) begin bad++; $display("FAIL ovf_pending e=%0d got=%0d exp=3", e, pending); end
            end
        end
        total++;
        if (blinks != 4) begin bad++; $display("FAIL ovf_blinks got=%0d exp=4", blinks); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_end got=%b exp=0", busy); end
        do_reset();
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        $display("test_overflow: blinks=%0d ovf cleared by reset", blinks);
    endtask

    task automatic test_gap_boundary();
        do_reset();
        step(1'b1);
        for (int e = 1; e <= 7; e++) step(1'b0);
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL gap_led_before got=%b exp=0", led); end
        step(1'b1);                                   // edge 8: last gap edge, queue empty
        total++;
        if (led !== 1'b1) begin bad++; $display("FAIL gap_direct_led got=%b exp=1", led); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL gap_direct_busy got=%b exp=1", busy); end
        total++;
        if (pending !== 2'd0) begin bad++; $display("FAIL gap_direct_pending got=%0d exp=0", pending); end
        step(1'b0);                                   // edge 9
        step(1'b1);                                   // edge 10: queued during on-time
        total++;
        if (pending !== 2'd1) begin bad++; $display("FAIL gap_queue_pending got=%0d exp=1", pending); end
        for (int e = 11; e <= 15; e++) step(1'b0);
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL gap2_led_before got=%b exp=0", led); end
        step(1'b1);                                   // edge 16: gap end with pend=1 plus pulse
        total++;
        if (led !== 1'b1) begin bad++; $display("FAIL gap2_led got=%b exp=1", led); end
        total++;
        if (pending !== 2'd1) begin bad++; $display("FAIL gap2_pending got=%0d exp=1", pending); end
        $display("test_gap_boundary: gap-to-on without idle checked twice");
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        total++;
        if (pending !== 2'd2) begin bad++; $display("FAIL mid_pending_pre got=%0d exp=2", pending); end
        rstn = 1'b0;
        step(1'b0);
        rstn = 1'b1;
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL mid_led got=%b exp=0", led); end
        total++;
        if (pending !== 2'd0) begin bad++; $display("FAIL mid_pending got=%0d exp=0", pending); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
        step(1'b0);
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL mid_idle_led got=%b exp=0", led); end
        step(1'b1);
        total++;
        if (led !== 1'b1) begin bad++; $display("FAIL mid_relaunch_led got=%b exp=1", led); end
        step(1'b0);
        total++;
        if (led !== 1'b1) begin bad++; $display("FAIL mid_relaunch_hold got=%b exp=1", led); end
        $display("test_reset_mid: queue discarded, new blink started");
    endtask

    task automatic test_reset_priority();
        do_reset();
        rstn = 1'b0;
        step(1'b1);
        rstn = 1'b1;
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL prio_led got=%b exp=0", led); end
        total++;
        if (pending !== 2'd0) begin bad++; $display("FAIL prio_pending got=%0d exp=0", pending); end
        step(1'b0);
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL prio_led_after got=%b exp=0", led); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL prio_busy_after got=%b exp=0", busy); end
        $display("test_reset_priority: pulse under reset ignored");
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rstn     = 1'b0;
        pulse_in = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_gap_boundary();
        test_reset_mid();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
